// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives rows active-low one-hot, synchronises and debounces
// the columns, and reports each accepted press as a one-cycle key_valid plus a held flag.
module keypad_scan #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_down
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    col_meta_q, csync_q;
   logic [DW-1:0] div_q;
   logic [3:0]    row_q, row_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          down_q, down_d;

   logic          tick;
   logic          single_zero;
   logic [1:0]    col_idx;
   logic [1:0]    row_idx;
   logic [3:0]    hit_code;
   logic [3:0]    row_rot;
   logic [CW-1:0] cnt_inc;

   assign tick        = (div_q == DIV_LAST);
   assign single_zero = $onehot(~csync_q);
   assign hit_code    = {row_idx, col_idx};
   assign row_rot     = {row_q[2:0], row_q[3]};
   assign cnt_inc     = cnt_q + CW'(1);

   always_comb begin
      col_idx = 2'd0;
      row_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!csync_q[i]) col_idx = 2'(i);
         if (!row_q[i])   row_idx = 2'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         col_meta_q <= 4'b1111;
         csync_q    <= 4'b1111;
         div_q      <= '0;
         state_q    <= ST_SCAN;
         row_q      <= 4'b1110;
         cnt_q      <= '0;
         cand_q     <= 4'd0;
         code_q     <= 4'd0;
         valid_q    <= 1'b0;
         down_q     <= 1'b0;
      end else begin
         col_meta_q <= col;
         csync_q    <= col_meta_q;
         div_q      <= tick ? '0 : div_q + DW'(1);
         state_q    <= state_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         cand_q     <= cand_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         down_q     <= down_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      code_d  = code_q;
      valid_d = 1'b0;
      down_d  = down_q;
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               // Multi-zero patterns are ghosting or chords; skip them and keep scanning.
               if (single_zero) begin
                  cand_d = hit_code;
                  if (CNT_DONE == CW'(1)) begin
                     code_d  = hit_code;
                     valid_d = 1'b1;
                     down_d  = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_HELD;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = ST_DEBOUNCE;
                  end
               end else begin
                  row_d = row_rot;
               end
            end
            ST_DEBOUNCE: begin
               if (single_zero && hit_code == cand_q) begin
                  if (cnt_inc == CNT_DONE) begin
                     code_d  = cand_q;
                     valid_d = 1'b1;
                     down_d  = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_HELD;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d   = '0;
                  row_d   = row_rot;
                  state_d = ST_SCAN;
               end
            end
            ST_HELD: begin
               if (csync_q == 4'b1111) begin
                  if (cnt_inc == CNT_DONE) begin
                     down_d  = 1'b0;
                     cnt_d   = '0;
                     row_d   = row_rot;
                     state_d = ST_SCAN;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_SCAN;
            end
         endcase
      end
   end

   assign row       = row_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a directed table of multi-tick steps followed by randomized
// key activity compared every cycle against a tick-level behavioural model.
module tb_keypad_scan;

   localparam int SCAN_DIV = 4;
   localparam int DS       = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_down;

   logic [15:0] keys = 16'h0000;
   logic        force_en = 1'b0;
   logic [3:0]  force_val = 4'hF;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .col       (col),
      .row       (row),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_down  (key_down)
   );

   // Keypad matrix: a pressed key (r,c) pulls column c low while row r is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
      if (force_en) col = force_val;
   end

   // Reference model: tracks slot number, scanned row index and a press/release
   // acceptance count, deciding once per slot on columns seen two clocks late.
   int         m_div, m_r, m_mode, m_cnt, m_cand;
   logic [3:0] m_s1, m_s2, m_code;
   logic       m_valid, m_down;

   always @(posedge clk) begin : ref_model
      logic [3:0] cs;
      bit         slot_end;
      int         zc;
      cs       = m_s2;
      slot_end = (m_div == SCAN_DIV - 1);
      if (!resetn) begin
         m_s1 = 4'hF; m_s2 = 4'hF; m_div = 0; m_r = 0; m_mode = 0;
         m_cnt = 0; m_cand = 0; m_valid = 1'b0; m_code = 4'd0; m_down = 1'b0;
      end else begin
         m_s2    = m_s1;
         m_s1    = col;
         m_div   = (m_div + 1) % SCAN_DIV;
         m_valid = 1'b0;
         if (slot_end) begin
            zc = -1;
            if ($countones(cs) == 3)
               for (int c = 0; c < 4; c++) if (!cs[c]) zc = c;
            if (m_mode == 0) begin
               if (zc >= 0) begin m_cand = m_r*4 + zc; m_cnt = 1; m_mode = 1; end
               else m_r = (m_r + 1) % 4;
            end else if (m_mode == 1) begin
               if (zc >= 0 && m_r*4 + zc == m_cand) m_cnt++;
               else begin m_cnt = 0; m_mode = 0; m_r = (m_r + 1) % 4; end
            end else begin
               if (cs == 4'hF) begin
                  m_cnt++;
                  if (m_cnt == DS) begin m_down = 1'b0; m_cnt = 0; m_mode = 0; m_r = (m_r + 1) % 4; end
               end else m_cnt = 0;
            end
            if (m_mode == 1 && m_cnt == DS) begin
               m_code = 4'(m_cand); m_valid = 1'b1; m_down = 1'b1; m_cnt = 0; m_mode = 2;
            end
         end
      end
   end

   typedef struct {
      string      name;
      int         cycles;
      bit         rstn;
      logic [15:0] keys;
      bit         fen;
      logic [3:0] fval;
      logic [3:0] erow;
      logic [3:0] ecode;
      logic       edown;
      int         evalid;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string n, input int cyc, input bit rs, input logic [15:0] k,
                      input bit fe, input logic [3:0] fv, input logic [3:0] er,
                      input logic [3:0] ec, input logic ed, input int ev);
      vec_t v;
      v.name = n; v.cycles = cyc; v.rstn = rs; v.keys = k; v.fen = fe; v.fval = fv;
      v.erow = er; v.ecode = ec; v.edown = ed; v.evalid = ev;
      tbl.push_back(v);
   endtask

   task automatic check(input string n, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   initial begin
      int nvalid;
      int sel, hold;
      logic [15:0] k;
      logic [3:0]  er;

      //   name            cyc rst keys     fen fval   row    code  down valid
      add("reset",          2, 0, 16'h0000, 0, 4'hF, 4'hE, 4'd0, 0, 0);
      add("idle_t1",        4, 1, 16'h0000, 0, 4'hF, 4'hD, 4'd0, 0, 0);
      add("idle_t2",        4, 1, 16'h0000, 0, 4'hF, 4'hB, 4'd0, 0, 0);
      add("idle_t3",        4, 1, 16'h0000, 0, 4'hF, 4'h7, 4'd0, 0, 0);
      add("idle_t4",        4, 1, 16'h0000, 0, 4'hF, 4'hE, 4'd0, 0, 0);
      add("press_reach",    8, 1, 16'h0200, 0, 4'hF, 4'hB, 4'd0, 0, 0);
      add("press_accept",  12, 1, 16'h0200, 0, 4'hF, 4'hB, 4'd9, 1, 1);
      add("press_hold",    16, 1, 16'h0200, 0, 4'hF, 4'hB, 4'd9, 1, 0);
      add("rel_clean2",     8, 1, 16'h0200, 1, 4'hF, 4'hB, 4'd9, 1, 0);
      add("rel_bounce",     4, 1, 16'h0200, 1, 4'hD, 4'hB, 4'd9, 1, 0);
      add("rel_clean2b",    8, 1, 16'h0200, 1, 4'hF, 4'hB, 4'd9, 1, 0);
      add("rel_clean3",     4, 1, 16'h0200, 1, 4'hF, 4'h7, 4'd9, 0, 0);
      add("bounce_reach",   8, 1, 16'h0080, 0, 4'hF, 4'hD, 4'd9, 0, 0);
      add("bounce_on",      8, 1, 16'h0080, 0, 4'hF, 4'hD, 4'd9, 0, 0);
      add("bounce_off",     4, 1, 16'h0000, 0, 4'hF, 4'hB, 4'd9, 0, 0);
      add("bounce_rot",     4, 1, 16'h0000, 0, 4'hF, 4'h7, 4'd9, 0, 0);
      add("ghost_reach",    4, 1, 16'h0005, 0, 4'hF, 4'hE, 4'd9, 0, 0);
      add("ghost_skip",     4, 1, 16'h0005, 0, 4'hF, 4'hD, 4'd9, 0, 0);
      add("ghost_loop",    16, 1, 16'h0005, 0, 4'hF, 4'hD, 4'd9, 0, 0);
      add("rehold_reach",   4, 1, 16'h0200, 0, 4'hF, 4'hB, 4'd9, 0, 0);
      add("rehold_accept", 12, 1, 16'h0200, 0, 4'hF, 4'hB, 4'd9, 1, 1);
      add("reset_held",     1, 0, 16'h0200, 0, 4'hF, 4'hE, 4'd0, 0, 0);
      add("reacq_reach",    8, 1, 16'h0200, 0, 4'hF, 4'hB, 4'd0, 0, 0);
      add("reacq_accept",  12, 1, 16'h0200, 0, 4'hF, 4'hB, 4'd9, 1, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         resetn    = tbl[i].rstn;
         keys      = tbl[i].keys;
         force_en  = tbl[i].fen;
         force_val = tbl[i].fval;
         nvalid    = 0;
         repeat (tbl[i].cycles) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid === 1'b1) nvalid++;
         end
         $display("step %0d %s: row=%b code=%0d down=%b valid_pulses=%0d",
                  i, tbl[i].name, row, key_code, key_down, nvalid);
         check({tbl[i].name, ".row"},   int'(row),      int'(tbl[i].erow));
         check({tbl[i].name, ".code"},  int'(key_code), int'(tbl[i].ecode));
         check({tbl[i].name, ".down"},  int'(key_down), int'(tbl[i].edown));
         check({tbl[i].name, ".valid"}, nvalid,         tbl[i].evalid);
      end

      force_en = 1'b0;
      for (int t = 0; t < 200; t++) begin
         sel = int'($urandom_range(0, 9));
         k   = 16'h0000;
         if (sel >= 4 && sel <= 7) k[$urandom_range(0, 15)] = 1'b1;
         else if (sel == 8) begin
            k[$urandom_range(0, 15)] = 1'b1;
            k[$urandom_range(0, 15)] = 1'b1;
         end
         keys   = k;
         resetn = (sel == 9) ? 1'b0 : 1'b1;
         hold   = (sel == 9) ? 1 : int'($urandom_range(1, 60));
         $display("rand %0d: keys=%h resetn=%b cycles=%0d", t, k, resetn, hold);
         repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            er = ~(4'b0001 << m_r);
            vectors++;
            if (row !== er || key_valid !== m_valid || key_code !== m_code || key_down !== m_down) begin
               miscompares++;
               $display("FAIL rand%0d: got row=%b valid=%b code=%0d down=%b expected row=%b valid=%b code=%0d down=%b",
                        t, row, key_valid, key_code, key_down, er, m_valid, m_code, m_down);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
